// File: rtl/rr_lock_arbiter_if.sv
// ============================================================================
// Module   : rr_lock_arbiter_if
// Purpose  : Request/grant bundle between N requesters and rr_lock_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rr_lock_arbiter_if #(
  parameter int N = 8,
  parameter int K = 3
);
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [K-1:0] gnt_id;
  logic         gnt_valid;
  logic         preempt;

  modport master (output req, input gnt, input gnt_id, input gnt_valid, input preempt);
  modport slave  (input req, output gnt, output gnt_id, output gnt_valid, output preempt);
endinterface

`default_nettype wire

// File: rtl/rr_lock_arbiter.sv
// ============================================================================
// Module   : rr_lock_arbiter (with helper priority_enc)
// Purpose  : Round-robin grant-locking arbiter with optional hold-limit rotation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module priority_enc #(
  parameter int N = 8,
  parameter int K = 3
) (
  input  wire logic [N-1:0] req,
  output logic      [K-1:0] idx,
  output logic              valid
);
  // Ascending scan so the highest set bit is the one left standing.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        idx   = K'(i);
        valid = 1'b1;
      end
    end
  end
endmodule

module rr_lock_arbiter #(
  parameter int N        = 8,
  parameter int K        = 3,
  parameter int MAX_HOLD = 16,
  parameter int CW       = 5
) (
  input wire logic          clk,
  input wire logic          rst_n,
  rr_lock_arbiter_if.slave  bus
);
  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_own  = 1'b1;

  logic [0:0]    r_state;
  logic [N-1:0]  r_gnt;
  logic [K-1:0]  r_gnt_id;
  logic          r_gnt_valid;
  logic          r_preempt;
  logic [K-1:0]  r_last;
  logic [CW-1:0] r_cnt;

  logic [0:0]    w_state_nxt;
  logic [N-1:0]  w_gnt_nxt;
  logic [K-1:0]  w_gnt_id_nxt;
  logic          w_gnt_valid_nxt;
  logic          w_preempt_nxt;
  logic [K-1:0]  w_last_nxt;
  logic [CW-1:0] w_cnt_nxt;

  logic [N-1:0]  w_req;
  logic [N-1:0]  w_req_x;
  logic [N-1:0]  w_mask;
  logic [K-1:0]  w_masked_idx;
  logic          w_masked_valid;
  logic [K-1:0]  w_full_idx;
  logic          w_full_valid;
  logic [K-1:0]  w_cand;
  logic [N-1:0]  w_cand_onehot;
  logic          w_own_req;
  logic          w_limit_hit;
  logic [CW-1:0] w_cnt_inc;

  assign w_req = bus.req;

  // While owning, the current owner is removed so a handoff never re-grants it.
  assign w_req_x = (r_state == c_st_own) ? (w_req & ~r_gnt) : w_req;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign w_mask[gi] = (r_last > K'(gi));
    end
  endgenerate

  priority_enc #(.N(N), .K(K)) u_enc_masked (
    .req   (w_req_x & w_mask),
    .idx   (w_masked_idx),
    .valid (w_masked_valid)
  );

  priority_enc #(.N(N), .K(K)) u_enc_full (
    .req   (w_req_x),
    .idx   (w_full_idx),
    .valid (w_full_valid)
  );

  assign w_cand        = w_masked_valid ? w_masked_idx : w_full_idx;
  assign w_cand_onehot = {{(N-1){1'b0}}, 1'b1} << w_cand;
  assign w_own_req     = w_req[r_gnt_id];

  generate
    if (MAX_HOLD != 0) begin : g_limit_on
      localparam logic [CW-1:0] c_max_hold = CW'(MAX_HOLD);
      assign w_limit_hit = (r_cnt == c_max_hold);
      assign w_cnt_inc   = (r_cnt == c_max_hold) ? r_cnt : r_cnt + 1'b1;
    end else begin : g_limit_off
      assign w_limit_hit = 1'b0;
      assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    end
  endgenerate

  // State register plus the registered outputs and pointer/counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_idle;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_preempt   <= 1'b0;
      r_last      <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_preempt   <= w_preempt_nxt;
      r_last      <= w_last_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_full_valid) w_state_nxt = c_st_own;
      c_st_own:  if (!w_own_req && !w_full_valid) w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_gnt_nxt       = r_gnt;
    w_gnt_id_nxt    = r_gnt_id;
    w_gnt_valid_nxt = r_gnt_valid;
    w_preempt_nxt   = 1'b0;
    w_last_nxt      = r_last;
    w_cnt_nxt       = r_cnt;
    case (r_state)
      c_st_idle: begin
        if (w_full_valid) begin
          w_gnt_nxt       = w_cand_onehot;
          w_gnt_id_nxt    = w_cand;
          w_gnt_valid_nxt = 1'b1;
          w_last_nxt      = w_cand;
          w_cnt_nxt       = CW'(1);
        end
      end
      c_st_own: begin
        if (w_own_req && !(w_limit_hit && w_full_valid)) begin
          w_cnt_nxt = w_cnt_inc;
        end else if (w_full_valid) begin
          // Handoff: either the owner released, or it was forced out by the limit.
          w_gnt_nxt       = w_cand_onehot;
          w_gnt_id_nxt    = w_cand;
          w_gnt_valid_nxt = 1'b1;
          w_last_nxt      = w_cand;
          w_cnt_nxt       = CW'(1);
          w_preempt_nxt   = w_own_req;
        end else begin
          w_gnt_nxt       = '0;
          w_gnt_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_gnt_nxt       = '0;
        w_gnt_valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_id    = r_gnt_id;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.preempt   = r_preempt;

endmodule

`default_nettype wire

// File: tb/tb_rr_lock_arbiter.sv
// ============================================================================
// Module   : tb_rr_lock_arbiter
// Purpose  : Directed self-checking bench for rr_lock_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_lock_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  rr_lock_arbiter_if #(.N(8), .K(3)) bus ();

  rr_lock_arbiter #(.N(8), .K(3), .MAX_HOLD(16), .CW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = 8'h00;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.req = 8'hFF;
    step();
    step();
    checks++;
    if (bus.gnt !== 8'h00) begin
      failures++; $display("FAIL reset_gnt actual=%h expected=00", bus.gnt);
    end
    checks++;
    if (bus.gnt_valid !== 1'b0 || bus.preempt !== 1'b0 || bus.gnt_id !== 3'd0) begin
      failures++;
      $display("FAIL reset_flags actual valid=%b preempt=%b id=%0d expected 0/0/0",
               bus.gnt_valid, bus.preempt, bus.gnt_id);
    end
    bus.req = 8'h00;
    rst_n   = 1'b1;
    step();
  endtask

  task automatic test_hold();
    bus.req = 8'b1010_0000;
    step();
    checks++;
    if (bus.gnt !== 8'h80 || bus.gnt_id !== 3'd7 || bus.gnt_valid !== 1'b1) begin
      failures++;
      $display("FAIL first_grant actual gnt=%h id=%0d valid=%b expected 80/7/1",
               bus.gnt, bus.gnt_id, bus.gnt_valid);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.gnt !== 8'h80 || bus.preempt !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d actual gnt=%h preempt=%b expected 80/0",
                 i, bus.gnt, bus.preempt);
      end
    end
  endtask

  task automatic test_handoff();
    bus.req = 8'b0010_0000;
    step();
    checks++;
    if (bus.gnt !== 8'h20 || bus.gnt_id !== 3'd5 || bus.gnt_valid !== 1'b1) begin
      failures++;
      $display("FAIL handoff actual gnt=%h id=%0d valid=%b expected 20/5/1",
               bus.gnt, bus.gnt_id, bus.gnt_valid);
    end
    bus.req = 8'h00;
    step();
    checks++;
    if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.gnt_id !== 3'd5) begin
      failures++;
      $display("FAIL release_idle actual gnt=%h valid=%b id=%0d expected 00/0/5",
               bus.gnt, bus.gnt_valid, bus.gnt_id);
    end
  endtask

  task automatic test_rotation();
    logic [2:0] order [9];
    logic [7:0] exp_gnt;
    order = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    do_reset();
    bus.req = 8'hFF;
    step();
    for (int k = 0; k < 9; k++) begin
      exp_gnt = 8'h01 << order[k];
      checks++;
      if (bus.gnt_id !== order[k] || bus.gnt !== exp_gnt || bus.gnt_valid !== 1'b1) begin
        failures++;
        $display("FAIL rotation k=%0d actual id=%0d gnt=%h valid=%b expected %0d/%h/1",
                 k, bus.gnt_id, bus.gnt, bus.gnt_valid, order[k], exp_gnt);
      end
      step();
      checks++;
      if (bus.gnt !== exp_gnt) begin
        failures++;
        $display("FAIL rotation_hold k=%0d actual gnt=%h expected %h", k, bus.gnt, exp_gnt);
      end
      bus.req[order[k]] = 1'b0;
      step();
      bus.req[order[k]] = 1'b1;
    end
    bus.req = 8'h00;
    step();
    step();
    checks++;
    if (bus.gnt_valid !== 1'b0) begin
      failures++; $display("FAIL rotation_idle actual valid=%b expected 0", bus.gnt_valid);
    end
  endtask

  task automatic test_uncontended();
    bus.req = 8'b0000_1000;
    step();
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (bus.gnt !== 8'h08 || bus.preempt !== 1'b0) begin
        failures++;
        $display("FAIL uncontended cyc=%0d actual gnt=%h preempt=%b expected 08/0",
                 i, bus.gnt, bus.preempt);
      end
      step();
    end
    bus.req = 8'h00;
    step();
  endtask

  task automatic test_preempt();
    do_reset();
    bus.req = 8'b0000_1010;
    step();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.gnt_id !== 3'd3 || bus.preempt !== 1'b0 || bus.gnt_valid !== 1'b1) begin
        failures++;
        $display("FAIL preempt_own3 cyc=%0d actual id=%0d preempt=%b expected 3/0",
                 i, bus.gnt_id, bus.preempt);
      end
      if (i < 15) step();
    end
    step();
    checks++;
    if (bus.gnt_id !== 3'd1 || bus.preempt !== 1'b1 || bus.gnt !== 8'h02) begin
      failures++;
      $display("FAIL preempt_to1 actual id=%0d preempt=%b gnt=%h expected 1/1/02",
               bus.gnt_id, bus.preempt, bus.gnt);
    end
    for (int i = 0; i < 15; i++) begin
      step();
      checks++;
      if (bus.gnt_id !== 3'd1 || bus.preempt !== 1'b0) begin
        failures++;
        $display("FAIL preempt_own1 cyc=%0d actual id=%0d preempt=%b expected 1/0",
                 i, bus.gnt_id, bus.preempt);
      end
    end
    step();
    checks++;
    if (bus.gnt_id !== 3'd3 || bus.preempt !== 1'b1 || bus.gnt !== 8'h08) begin
      failures++;
      $display("FAIL preempt_to3 actual id=%0d preempt=%b gnt=%h expected 3/1/08",
               bus.gnt_id, bus.preempt, bus.gnt);
    end
  endtask

  // Entered with preempt high from the previous task.
  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.preempt !== 1'b0) begin
      failures++;
      $display("FAIL async_reset actual gnt=%h valid=%b preempt=%b expected 00/0/0",
               bus.gnt, bus.gnt_valid, bus.preempt);
    end
    bus.req = 8'b0000_0011;
    step();
    #2;
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.gnt_id !== 3'd1 || bus.gnt !== 8'h02 || bus.gnt_valid !== 1'b1) begin
      failures++;
      $display("FAIL restart actual id=%0d gnt=%h valid=%b expected 1/02/1",
               bus.gnt_id, bus.gnt, bus.gnt_valid);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    test_reset();
    test_hold();
    test_handoff();
    test_rotation();
    test_uncontended();
    test_preempt();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- Round-robin, grant-locking arbiter for N requesters sharing one resource.
- Selection uses two priority_enc instances:
  - one over the masked request vector (indices strictly below the last grant);
  - one over the full request vector, used when the mask is empty.
- Grant is registered and held while the owner keeps its request high.
- An optional hold limit forces rotation when others are waiting. The block sits in front of any shared datapath port (bus, memory bank, encoder lane).

Parameters:
- N, 8, number of requesters; power of two, >= 2.
- K, 3, index width; K = log2(N).
- MAX_HOLD, 16, max consecutive grant cycles before forced rotation when contended; 0 disables the limit.
- CW, 5, hold counter width; must satisfy 2^CW > MAX_HOLD.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request vector; requester i holds req[i] high until done.
- gnt  output  N  registered one-hot grant; all zero when idle.
- gnt_id  output  K  index of current owner; valid only when gnt_valid.
- gnt_valid  output  1  high while any grant is active.
- preempt  output  1  one-cycle pulse, registered; high in the first cycle of a grant caused by the hold limit.

Behaviour:
- Reset, asynchronous, while rst_n low:
  - gnt=0, gnt_id=0, gnt_valid=0, preempt=0.
  - last=0 (pointer), hold counter=0, state IDLE.
- Selection (combinational):
  - mask = indices < last.
  - Candidate = highest set index of (req & mask) if nonzero, else highest set index of req.
  - So after reset (last=0) the highest requesting index wins.
  - Descending order wraps from 0 back to N-1.
- States: IDLE, OWN.
- IDLE:
  - If req nonzero: next cycle gnt=onehot(cand), gnt_id=cand, gnt_valid=1, last=cand, counter=1, go OWN.
  - Latency: req rise to gnt = 1 cycle.
- OWN, owner = gnt_id:
  - req[owner] high, and either no limit hit or no other requester: hold grant; counter increments, saturating at MAX_HOLD.
  - req[owner] low, other requests present: next cycle grant moves directly to the new candidate (no idle bubble); counter=1. Mask is based on the updated last = old owner.
  - req[owner] low, no other requests: next cycle gnt=0, gnt_valid=0, go IDLE. gnt_id and last keep their values.
  - MAX_HOLD!=0, counter == MAX_HOLD, req[owner] high, another req bit set: next cycle grant moves to candidate chosen with owner bit excluded; preempt=1 for that cycle; counter=1.
- Owner exclusion: a dropped or preempted owner is never re-granted in the handoff cycle, even if its req re-rises that same cycle.
- Uncontended owner is never preempted; the counter simply saturates.
- req bits for non-owners may toggle freely; only the level at the sampling edge matters.
- At most one gnt bit set at any time; gnt_id == index of that bit whenever gnt_valid.
- Reset mid-grant: all outputs clear immediately (asynchronous). Arbitration restarts from last=0 after rst_n deasserts.

Test Plan:
- Reset, then req=8'b1010_0000 -> cycle+1: gnt=8'b1000_0000, gnt_id=7; hold 5 cycles; gnt stable, preempt=0.
- With owner 7, drop req[7] while req[5]=1 -> next cycle gnt=8'b0010_0000, gnt_id=5, no gnt_valid gap.
- Drive all 8 requests, each requester drops after 2 cycles and re-raises -> grant order 7,6,5,4,3,2,1,0,7 (wrap).
- Requester 3 alone held for 40 cycles (MAX_HOLD=16) -> gnt stays 8'b0000_1000, preempt never 1.
- Requesters 3 and 1 held continuously -> 3 granted first, owns exactly 16 cycles; then gnt_id=1 with preempt=1 for one cycle; after 16 more cycles, back to 3 with preempt=1.
- Assert rst_n=0 mid-grant between clock edges -> gnt, gnt_valid, preempt go 0 without a clock edge. Release with req=8'b0000_0011 -> gnt_id=1 one cycle after the first clock edge.
